// File: rtl/cpu_pkg.sv
// Shared definitions for the reversible CPU front end: datapath widths,
// the fetch FSM state type and the default program counter after clear.
package cpu_pkg;

    localparam int CPU_ADDR_W = 12;
    localparam int CPU_DATA_W = 12;

    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = 12'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2,
        EXEC = 2'd3
    } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/pc_updown.sv
// Program counter: synchronous clear, parallel load and enabled up/down step.
// All arithmetic wraps modulo 2^W, with no carry or borrow flag.
module pc_updown #(
    parameter int          W         = 12,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_dir,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Clear wins over load, and load wins over a step.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= i_dir ? (r_count - 1'b1) : (r_count + 1'b1);
        end
    end

    assign o_count = r_count;

endmodule : pc_updown

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage: steps the PC forward/backward, fetches one word per
// instruction over a req/ack handshake and loads it into the IR with a one-cycle strobe.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = cpu_pkg::CPU_ADDR_W,
    parameter int                DATA_W   = cpu_pkg::CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::CPU_RESET_PC
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic              dir,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exec_done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir_data,
    output logic              ir_wr_e,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [DATA_W-1:0] r_ir_data;
    logic [ADDR_W-1:0] w_pc;

    logic w_in_req;
    logic w_in_exec;
    logic w_capture;
    logic w_retire;
    logic w_mem_req;
    logic w_ir_wr_e;
    logic w_busy;

    assign w_in_req  = (r_state == REQ);
    assign w_in_exec = (r_state == EXEC);
    assign w_capture = w_in_req && mem_ack;
    // The PC only moves on the edge that retires the current instruction.
    assign w_retire  = w_in_exec && exec_done;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_req    = 1'b0;
        w_ir_wr_e    = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (run) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                w_mem_req = 1'b1;
                if (mem_ack) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_ir_wr_e    = 1'b1;
                w_state_next = EXEC;
            end
            EXEC: begin
                if (exec_done) begin
                    w_state_next = run ? REQ : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Only written by an acknowledged read, so the IR sees a stable word during LOAD.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_ir_data <= '0;
        end else if (w_capture) begin
            r_ir_data <= mem_rdata;
        end
    end

    pc_updown #(
        .W         (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .i_clr      (clr),
        .i_load     (w_retire && br_valid),
        .i_load_val (br_target),
        .i_en       (w_retire),
        .i_dir      (dir),
        .o_count    (w_pc)
    );

    assign mem_req  = w_mem_req;
    assign mem_addr = w_pc;
    assign pc       = w_pc;
    assign ir_data  = r_ir_data;
    assign ir_wr_e  = w_ir_wr_e;
    assign busy     = w_busy;

endmodule : fetch_sequencer
